ad3542_spi_rx: RTL and testbench
================================

Name: ad3542_spi_rx

Overview:
- Receive-side model of the AD3542 serial interface: the SPI responder that decodes the frames a DAC host interface drives on sclk/cs/sdio0/sdio1.
- Oversamples the SPI lines in the system clock domain and emits decoded register writes.
- Reconstructs the two 16-bit DAC channel codes.
- Synthesizable, so it serves both as loopback checker on the board and as bench responder.

Parameters:
- CH0_ADDR, 7'h2B, address of channel-0 code MSB byte; LSB byte at CH0_ADDR-1.
- CH1_ADDR, 7'h2D, address of channel-1 code MSB byte; LSB byte at CH1_ADDR-1.
- SYNC_STAGES, 2, synchronizer depth for all SPI inputs (min 2).

Ports:
- clk  in  1  system clock; must be at least 4x spi_sclk frequency.
- reset_x  in  1  asynchronous, active-low reset.
- dual_mode  in  1  1 = data phase uses sdio1+sdio0; 0 = sdio0 only.
- spi_sclk  in  1  SPI clock, mode 0, asynchronous to clk.
- spi_cs  in  1  chip select, active-low.
- spi_sdio0  in  1  serial data lane 0.
- spi_sdio1  in  1  serial data lane 1.
- wr_valid  out  1  one-cycle pulse: a write byte was decoded.
- wr_addr  out  7  register address of the decoded byte.
- wr_data  out  8  decoded byte.
- rd_req  out  1  one-cycle pulse: a read instruction was received.
- rd_addr  out  7  address carried by the read instruction.
- dac_0  out  16  last committed channel-0 code.
- dac_1  out  16  last committed channel-1 code.
- dac_0_upd  out  1  one-cycle pulse when dac_0 is updated.
- dac_1_upd  out  1  one-cycle pulse when dac_1 is updated.
- frame_err  out  1  one-cycle pulse: cs rose with a partial byte.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset values: all outputs 0, staging registers 0, state IDLE.
- Input synchronization: all SPI inputs pass through SYNC_STAGES flops.
- Edge cycle: the clk cycle in which the synchronized sclk 0->1 transition is detected. Data lanes are sampled in that same cycle, from the same synchronizer depth.
- SPI mode 0, MSB first. Falling sclk edges are ignored.
- dual_mode is latched when cs falls and held for the whole frame.
- FSM IDLE:
  - Synchronized cs falls -> INSTR.
  - Clear bit count; latch dual_mode.
- FSM INSTR:
  - Always single lane: 8 bits on sdio0.
  - bit7 = R/W (1 = read), bits6:0 = address.
  - After the 8th edge, write (R/W=0) -> DATA with cur_addr = address.
  - After the 8th edge, read (R/W=1) -> rd_req pulse plus rd_addr, then go to IGNORE.
- FSM DATA:
  - Single lane: 8 edges per byte.
  - Dual lane: 4 edges per byte. Each edge shifts in {sdio1, sdio0}, so the first edge gives bits 7 and 6.
  - Byte complete -> next cycle: wr_valid=1, wr_addr=cur_addr, wr_data=byte.
  - Then cur_addr decrements, wrapping 7'h00 -> 7'h7F.
  - The byte stream continues until cs rises.
- FSM IGNORE: discard all edges until cs rises.
- Frame end: synchronized cs rising in any state -> IDLE.
  - frame_err pulses if the bit count within the current instruction or data byte is nonzero at that moment.
  - Partial bytes are dropped and never emitted.
  - cs high with no frame in progress is not an error.
- DAC code reconstruction:
  - A write byte at CHn_ADDR loads MSB staging register n.
  - A write byte at CHn_ADDR-1 commits dac_n = {staging_n, byte}.
  - dac_n and the dac_n_upd pulse take effect one cycle after that byte's wr_valid.
  - The staging register persists across frames.
  - Both channels committing from separate bytes is legal; each commit produces its own pulse.
- Simultaneous events:
  - cs rising in the same cycle as the final edge of a byte: the edge is processed first, the byte is emitted, and there is no frame_err.
  - cs falling in the same cycle as an sclk edge: the edge is ignored.
- Asynchronous reset mid-frame: immediate return to IDLE with all outputs 0. Nothing is emitted until the next cs fall.

Decomposition:
- Shared package ad3542_pkg:
  - FSM state enum (IDLE, INSTR, DATA, IGNORE).
  - Instruction field positions (RW_BIT=7).
  - Default channel address constants.
- Sub-module spi_in_sync:
  - SYNC_STAGES-deep synchronizer for the sclk/cs/sdio0/sdio1 bundle.
  - Outputs sclk_rise and cs_fall/cs_rise strobes.
- Top module: FSM, shift register, address counter, DAC staging/commit logic.

Test Plan:
- Single-lane write, sclk = clk/8: instruction 8'h2B, data 8'hA5, 8'h3C -> wr_valid x2 with (2B,A5) then (2A,3C); dac_0=16'hA53C; one dac_0_upd pulse.
- Dual-lane write with dual_mode=1: instruction 8'h2D, data 8'h12, 8'h34 -> each data byte takes 4 edges; dac_1=16'h1234; dac_1_upd pulse; dac_0 unchanged.
- Read instruction 8'hAB followed by 16 further clocks -> rd_req pulse with rd_addr=7'h2B; no wr_valid; busy falls after cs rises.
- cs rises after 5 data bits -> frame_err pulse; no wr_valid for the partial byte; the next frame decodes normally.
- Address wrap: write to 7'h00 with 2 data bytes -> wr_addr 00 then 7F.
- reset_x asserted mid-byte -> all outputs 0 immediately; a fresh frame after release decodes correctly.

Source files
------------

// File: rtl/ad3542_pkg.sv
// Shared types and constants for the AD3542 SPI receive path.
package ad3542_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INSTR  = 2'd1,
        DATA   = 2'd2,
        IGNORE = 2'd3
    } state_e;

    localparam int         RW_BIT       = 7;
    localparam logic [6:0] CH0_ADDR_DEF = 7'h2B;
    localparam logic [6:0] CH1_ADDR_DEF = 7'h2D;

    // Address of the LSB byte that sits just below a channel's MSB byte.
    function automatic logic [6:0] lsb_addr(input logic [6:0] msb_addr);
        return msb_addr - 7'd1;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizes the SPI line bundle into clk and produces sclk/cs edge strobes.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs,
    input  logic sdio0,
    input  logic sdio1,
    output logic sclk_rise,
    output logic cs_fall,
    output logic cs_rise,
    output logic sdio0_s,
    output logic sdio1_s
);

    localparam int         W          = 4 * SYNC_STAGES;
    // Bundle order {cs, sclk, sdio1, sdio0}; the idle bus has cs high.
    localparam logic [3:0] IDLE_LINES = 4'b1000;

    logic [W-1:0] chain_q, chain_d;
    logic [1:0]   prev_q, prev_d;
    logic [3:0]   lines;

    always_comb begin
        chain_d   = {chain_q[W-5:0], cs, sclk, sdio1, sdio0};
        lines     = chain_q[W-1 -: 4];
        prev_d    = lines[3:2];
        sclk_rise = lines[2] & ~prev_q[0];
        cs_fall   = ~lines[3] & prev_q[1];
        cs_rise   = lines[3] & ~prev_q[1];
        sdio1_s   = lines[1];
        sdio0_s   = lines[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {SYNC_STAGES{IDLE_LINES}};
            prev_q  <= 2'b10;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: rtl/ad3542_spi_rx.sv
// AD3542 SPI responder: decodes instruction/data frames into register writes,
// read requests and reconstructed 16-bit DAC channel codes.
module ad3542_spi_rx
    import ad3542_pkg::*;
#(
    parameter logic [6:0] CH0_ADDR    = CH0_ADDR_DEF,
    parameter logic [6:0] CH1_ADDR    = CH1_ADDR_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        dual_mode,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_sdio0,
    input  logic        spi_sdio1,
    output logic        wr_valid,
    output logic [6:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    output logic [6:0]  rd_addr,
    output logic [15:0] dac_0,
    output logic [15:0] dac_1,
    output logic        dac_0_upd,
    output logic        dac_1_upd,
    output logic        frame_err,
    output logic        busy
);

    logic sclk_rise, cs_fall, cs_rise, sdio0_s, sdio1_s;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (reset_x),
        .sclk      (spi_sclk),
        .cs        (spi_cs),
        .sdio0     (spi_sdio0),
        .sdio1     (spi_sdio1),
        .sclk_rise (sclk_rise),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .sdio0_s   (sdio0_s),
        .sdio1_s   (sdio1_s)
    );

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        dual_q, dual_d;
    logic [6:0]  cur_addr_q, cur_addr_d;
    logic        wr_valid_q, wr_valid_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        rd_req_q, rd_req_d;
    logic [6:0]  rd_addr_q, rd_addr_d;
    logic [7:0]  stg_0_q, stg_0_d, stg_1_q, stg_1_d;
    logic [15:0] dac_0_q, dac_0_d, dac_1_q, dac_1_d;
    logic        dac_0_upd_q, dac_0_upd_d, dac_1_upd_q, dac_1_upd_d;
    logic        frame_err_q, frame_err_d;

    logic        two_lane;
    logic        byte_last;
    logic [7:0]  shift_nxt;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        dual_d      = dual_q;
        cur_addr_d  = cur_addr_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_req_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        stg_0_d     = stg_0_q;
        stg_1_d     = stg_1_q;
        dac_0_d     = dac_0_q;
        dac_1_d     = dac_1_q;
        dac_0_upd_d = 1'b0;
        dac_1_upd_d = 1'b0;
        frame_err_d = 1'b0;

        // The instruction byte is always single lane; only data bytes use two.
        two_lane  = (state_q == DATA) && dual_q;
        byte_last = two_lane ? (bit_cnt_q == 3'd3) : (bit_cnt_q == 3'd7);
        shift_nxt = two_lane ? {shift_q[5:0], sdio1_s, sdio0_s}
                             : {shift_q[6:0], sdio0_s};

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = INSTR;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                    dual_d    = dual_mode;
                end
            end
            INSTR: begin
                if (sclk_rise) begin
                    shift_d   = shift_nxt;
                    bit_cnt_d = byte_last ? 3'd0 : bit_cnt_q + 3'd1;
                    if (byte_last) begin
                        if (shift_nxt[RW_BIT]) begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = shift_nxt[6:0];
                            state_d   = IGNORE;
                        end else begin
                            cur_addr_d = shift_nxt[6:0];
                            state_d    = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (sclk_rise) begin
                    shift_d   = shift_nxt;
                    bit_cnt_d = byte_last ? 3'd0 : bit_cnt_q + 3'd1;
                    if (byte_last) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = cur_addr_q;
                        wr_data_d  = shift_nxt;
                        cur_addr_d = cur_addr_q - 7'd1;
                    end
                end
            end
            default: ;
        endcase

        // The edge above is applied first, so a byte finished together with cs rise is no error.
        if (cs_rise && (state_q != IDLE)) begin
            state_d = IDLE;
            if (((state_q == INSTR) || (state_q == DATA)) && (bit_cnt_d != 3'd0)) begin
                frame_err_d = 1'b1;
            end
        end

        if (wr_valid_q) begin
            if (wr_addr_q == CH0_ADDR) stg_0_d = wr_data_q;
            if (wr_addr_q == CH1_ADDR) stg_1_d = wr_data_q;
            if (wr_addr_q == lsb_addr(CH0_ADDR)) begin
                dac_0_d     = {stg_0_q, wr_data_q};
                dac_0_upd_d = 1'b1;
            end
            if (wr_addr_q == lsb_addr(CH1_ADDR)) begin
                dac_1_d     = {stg_1_q, wr_data_q};
                dac_1_upd_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            dual_q      <= 1'b0;
            cur_addr_q  <= 7'h00;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 7'h00;
            wr_data_q   <= 8'h00;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= 7'h00;
            stg_0_q     <= 8'h00;
            stg_1_q     <= 8'h00;
            dac_0_q     <= 16'h0000;
            dac_1_q     <= 16'h0000;
            dac_0_upd_q <= 1'b0;
            dac_1_upd_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            dual_q      <= dual_d;
            cur_addr_q  <= cur_addr_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            stg_0_q     <= stg_0_d;
            stg_1_q     <= stg_1_d;
            dac_0_q     <= dac_0_d;
            dac_1_q     <= dac_1_d;
            dac_0_upd_q <= dac_0_upd_d;
            dac_1_upd_q <= dac_1_upd_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign dac_0     = dac_0_q;
    assign dac_1     = dac_1_q;
    assign dac_0_upd = dac_0_upd_q;
    assign dac_1_upd = dac_1_upd_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ad3542_spi_rx.sv
// Bench for ad3542_spi_rx: drives SPI frames and checks decoded writes,
// read requests, DAC codes and frame errors against a byte-level model.
module tb_ad3542_spi_rx;

    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        reset_x = 1'b0;
    logic        dual_mode = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_sdio0 = 1'b0;
    logic        spi_sdio1 = 1'b0;
    logic        wr_valid, rd_req, dac_0_upd, dac_1_upd, frame_err, busy;
    logic [6:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic [15:0] dac_0, dac_1;

    ad3542_spi_rx dut (
        .clk       (clk),
        .reset_x   (reset_x),
        .dual_mode (dual_mode),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_sdio0 (spi_sdio0),
        .spi_sdio1 (spi_sdio1),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .dac_0     (dac_0),
        .dac_1     (dac_1),
        .dac_0_upd (dac_0_upd),
        .dac_1_upd (dac_1_upd),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Scoreboard state and reference model.
    logic [14:0] exp_q[$];
    logic [6:0]  exp_rd_q[$];
    logic [7:0]  tx_q[$];
    logic [14:0] mon_e;
    logic [6:0]  mon_r;
    int          wr_cnt = 0, upd0_cnt = 0, upd1_cnt = 0, ferr_cnt = 0;
    int          m_upd0 = 0, m_upd1 = 0, m_ferr = 0;
    logic [7:0]  m_stg0 = 8'h00, m_stg1 = 8'h00;
    logic [15:0] m_dac0 = 16'h0000, m_dac1 = 16'h0000;

    always @(negedge clk) begin
        if (reset_x) begin
            if (wr_valid) begin
                wr_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected got=%h/%h exp=none", wr_addr, wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== mon_e) begin
                        bad++;
                        $display("FAIL wr_stream got=%h/%h exp=%h/%h", wr_addr, wr_data,
                                 mon_e[14:8], mon_e[7:0]);
                    end
                end
            end
            if (rd_req) begin
                total++;
                if (exp_rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_unexpected got=%h exp=none", rd_addr);
                end else begin
                    mon_r = exp_rd_q.pop_front();
                    if (rd_addr !== mon_r) begin
                        bad++;
                        $display("FAIL rd_addr got=%h exp=%h", rd_addr, mon_r);
                    end
                end
            end
            if (dac_0_upd) upd0_cnt++;
            if (dac_1_upd) upd1_cnt++;
            if (frame_err) ferr_cnt++;
        end
    end

    // Byte-level model: tx_q holds instruction then data bytes; part = trailing partial bits.
    task automatic model_frame(input int part);
        logic [7:0] instr;
        logic [6:0] a;
        logic [7:0] b;
        instr = tx_q[0];
        if (instr[7]) begin
            exp_rd_q.push_back(instr[6:0]);
        end else begin
            a = instr[6:0];
            for (int i = 1; i < tx_q.size(); i++) begin
                b = tx_q[i];
                exp_q.push_back({a, b});
                if (a == 7'h2B) m_stg0 = b;
                if (a == 7'h2D) m_stg1 = b;
                if (a == 7'h2A) begin m_dac0 = {m_stg0, b}; m_upd0++; end
                if (a == 7'h2C) begin m_dac1 = {m_stg1, b}; m_upd1++; end
                a = a - 7'd1;
            end
            if (part != 0) m_ferr++;
        end
    endtask

    task automatic pulse();
        #HALF spi_sclk = 1'b1;
        #HALF spi_sclk = 1'b0;
    endtask

    task automatic frame_start(input logic dual);
        dual_mode = dual;
        spi_sclk  = 1'b0;
        #HALF spi_cs = 1'b0;
        #HALF dual_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic frame_end();
        #HALF spi_cs = 1'b1;
        #(HALF * 3);
    endtask

    task automatic send_byte(input logic [7:0] b, input int lanes);
        if (lanes == 2) begin
            for (int i = 3; i >= 0; i--) begin
                spi_sdio1 = b[2*i+1];
                spi_sdio0 = b[2*i];
                pulse();
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                spi_sdio0 = b[i];
                spi_sdio1 = 1'($urandom_range(0, 1));
                pulse();
            end
        end
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            spi_sdio0 = 1'($urandom_range(0, 1));
            spi_sdio1 = 1'($urandom_range(0, 1));
            pulse();
        end
    endtask

    task automatic drive_frame(input logic dual, input int part);
        model_frame(part);
        frame_start(dual);
        send_byte(tx_q[0], 1);
        for (int i = 1; i < tx_q.size(); i++) send_byte(tx_q[i], dual ? 2 : 1);
        send_bits(part);
        frame_end();
    endtask

    task automatic test_reset();
        #23;
        total++;
        if ({wr_valid, rd_req, dac_0_upd, dac_1_upd, frame_err, busy} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=000000",
                            {wr_valid, rd_req, dac_0_upd, dac_1_upd, frame_err, busy});
        end
        total++;
        if ({dac_0, dac_1} !== 32'h0) begin
            bad++; $display("FAIL reset_dac got=%h exp=0", {dac_0, dac_1});
        end
        total++;
        if ({wr_addr, wr_data, rd_addr} !== 22'h0) begin
            bad++; $display("FAIL reset_regs got=%h exp=0", {wr_addr, wr_data, rd_addr});
        end
        reset_x = 1'b1;
        #100;
    endtask

    task automatic test_single_write();
        tx_q = '{8'h2B, 8'hA5, 8'h3C};
        drive_frame(1'b0, 0);
        total++;
        if (dac_0 !== 16'hA53C) begin bad++; $display("FAIL single_dac0 got=%h exp=a53c", dac_0); end
        total++;
        if (upd0_cnt !== 1) begin bad++; $display("FAIL single_upd0 got=%0d exp=1", upd0_cnt); end
        total++;
        if (wr_cnt !== 2) begin bad++; $display("FAIL single_wr_cnt got=%0d exp=2", wr_cnt); end
    endtask

    task automatic test_dual_write();
        tx_q = '{8'h2D, 8'h12, 8'h34};
        drive_frame(1'b1, 0);
        total++;
        if (dac_1 !== 16'h1234) begin bad++; $display("FAIL dual_dac1 got=%h exp=1234", dac_1); end
        total++;
        if (dac_0 !== 16'hA53C) begin bad++; $display("FAIL dual_dac0 got=%h exp=a53c", dac_0); end
        total++;
        if (upd1_cnt !== 1) begin bad++; $display("FAIL dual_upd1 got=%0d exp=1", upd1_cnt); end
    endtask

    task automatic test_read();
        int w0;
        w0 = wr_cnt;
        tx_q = '{8'hAB};
        model_frame(0);
        frame_start(1'b0);
        send_byte(8'hAB, 1);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL read_busy_in got=%b exp=1", busy); end
        send_bits(16);
        frame_end();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_out got=%b exp=0", busy); end
        total++;
        if ((wr_cnt - w0) !== 0 || exp_rd_q.size() !== 0 || ferr_cnt !== m_ferr) begin
            bad++; $display("FAIL read_result got=wr%0d/rd_left%0d/err%0d exp=wr0/rd_left0/err%0d",
                            wr_cnt - w0, exp_rd_q.size(), ferr_cnt, m_ferr);
        end
    endtask

    task automatic test_partial();
        tx_q = '{8'h2B};
        drive_frame(1'b0, 5);
        total++;
        if (ferr_cnt !== 1) begin bad++; $display("FAIL partial_data_err got=%0d exp=1", ferr_cnt); end
        m_ferr++;
        frame_start(1'b0);
        send_bits(3);
        frame_end();
        total++;
        if (ferr_cnt !== 2) begin bad++; $display("FAIL partial_instr_err got=%0d exp=2", ferr_cnt); end
        tx_q = '{8'h2D, 8'h56, 8'h78};
        drive_frame(1'b0, 0);
        total++;
        if (dac_1 !== 16'h5678) begin bad++; $display("FAIL partial_next_dac1 got=%h exp=5678", dac_1); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL partial_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        tx_q = '{8'h00, 8'h9E, 8'h4F};
        drive_frame(1'($urandom_range(0, 1)), 0);
        total++;
        if (exp_q.size() !== 0 || ferr_cnt !== m_ferr) begin
            bad++; $display("FAIL wrap_pending got=%0d/%0d exp=0/%0d", exp_q.size(), ferr_cnt, m_ferr);
        end
    endtask

    task automatic test_cs_with_last_edge();
        tx_q = '{8'h2B, 8'hC3};
        model_frame(0);
        frame_start(1'b0);
        send_byte(8'h2B, 1);
        for (int i = 7; i >= 1; i--) begin
            spi_sdio0 = tx_q[1][i];
            pulse();
        end
        spi_sdio0 = 1'b1;
        #HALF;
        spi_sclk = 1'b1;
        spi_cs   = 1'b1;
        #HALF spi_sclk = 1'b0;
        #(HALF * 3);
        total++;
        if (ferr_cnt !== m_ferr || exp_q.size() !== 0) begin
            bad++; $display("FAIL cs_last_edge got=err%0d/left%0d exp=err%0d/left0",
                            ferr_cnt, exp_q.size(), m_ferr);
        end
    endtask

    task automatic test_reset_mid();
        tx_q = '{8'h2B, 8'hA5};
        model_frame(0);
        frame_start(1'b0);
        send_byte(8'h2B, 1);
        send_byte(8'hA5, 1);
        send_bits(3);
        #7 reset_x = 1'b0;
        #1;
        total++;
        if ({dac_0, dac_1, wr_valid, busy, frame_err, rd_req} !== 36'h0) begin
            bad++; $display("FAIL reset_mid_outs got=%h exp=0", {dac_0, dac_1, wr_valid, busy, frame_err, rd_req});
        end
        spi_cs = 1'b1;
        #50 reset_x = 1'b1;
        m_stg0 = 8'h00; m_stg1 = 8'h00; m_dac0 = 16'h0; m_dac1 = 16'h0;
        #100;
        tx_q = '{8'h2A, 8'h77};
        drive_frame(1'b0, 0);
        total++;
        if (dac_0 !== 16'h0077) begin bad++; $display("FAIL reset_mid_fresh got=%h exp=0077", dac_0); end
    endtask

    task automatic test_random();
        logic [6:0] a;
        logic       rw, dual;
        int         n, part;
        for (int f = 0; f < 24; f++) begin
            case ($urandom_range(0, 7))
                0: a = 7'h2A;
                1: a = 7'h2B;
                2: a = 7'h2C;
                3: a = 7'h2D;
                4: a = 7'h00;
                5: a = 7'h7F;
                default: a = 7'($urandom_range(0, 127));
            endcase
            rw   = ($urandom_range(0, 4) == 0);
            dual = 1'($urandom_range(0, 1));
            n    = $urandom_range(0, 4);
            part = rw ? $urandom_range(0, 5) : (dual ? $urandom_range(0, 3) : $urandom_range(0, 7));
            tx_q = '{};
            tx_q.push_back({rw, a});
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            drive_frame(dual, part);
        end
        total++;
        if (dac_0 !== m_dac0) begin bad++; $display("FAIL rand_dac0 got=%h exp=%h", dac_0, m_dac0); end
        total++;
        if (dac_1 !== m_dac1) begin bad++; $display("FAIL rand_dac1 got=%h exp=%h", dac_1, m_dac1); end
        total++;
        if (upd0_cnt !== m_upd0 || upd1_cnt !== m_upd1) begin
            bad++; $display("FAIL rand_upd got=%0d/%0d exp=%0d/%0d", upd0_cnt, upd1_cnt, m_upd0, m_upd1);
        end
        total++;
        if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL rand_ferr got=%0d exp=%0d", ferr_cnt, m_ferr); end
        total++;
        if (exp_q.size() !== 0 || exp_rd_q.size() !== 0) begin
            bad++; $display("FAIL rand_pending got=%0d/%0d exp=0/0", exp_q.size(), exp_rd_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_dual_write();
        test_read();
        test_partial();
        test_wrap();
        test_cs_with_last_edge();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
